slink_channel_repack_buffer: RTL and testbench
==============================================

Name: slink_channel_repack_buffer

Overview:
- Sits directly downstream of the RX channel despread shift register in the channel allocator.
- Consumes compacted words in which only the first K of Width lanes carry data.
- Packs these partial words back-to-back into full Width-element output words, so the link always delivers dense words regardless of how many channels are enabled.
- A flush request drains a trailing partial word.

Parameters:
- element_t, logic[15:0], type of one lane element.
- Width, 8, number of lanes per word; must be >= 2.
- FlushTimeout, 64, idle cycles before auto-flush; used only with the optional feature; >= 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- clear_i  in  1  synchronous clear; drops all buffered data.
- flush_i  in  1  single-cycle request to emit buffered partial data.
- valid_i  in  Width  lane-valid mask; must be thermometer (lanes 0..K-1 set).
- ready_o  out  1  input accepted when valid_i!=0 and ready_o=1.
- data_i  in  Width x element_t  input lanes.
- valid_o  out  Width  output lane mask; all ones for a full word, thermometer for a flushed partial word, 0 when idle.
- ready_i  in  1  downstream ready.
- data_o  out  Width x element_t  output word; lane 0 holds the oldest element.

Behaviour:
- Storage: FIFO-ordered element buffer of 2*Width entries, plus fill counter of $clog2(2*Width+1) bits and a flush_pending flag.
- Reset and clear values:
  - rst_i (asynchronous, any time, including mid-transfer) sets fill=0, flush_pending=0, buffer=0, valid_o=0, data_o=0.
  - ready_o reads 1 one cycle after reset release.
  - clear_i has the same effect synchronously and has priority over every other event in that cycle.
- Input side:
  - K = popcount(valid_i).
  - ready_o = !flush_pending && fill <= Width.
  - On input handshake, lanes 0..K-1 are appended at position fill_eff, where fill_eff = fill - Width if an output handshake occurs in the same cycle, else fill.
  - valid_i=0 is never a transaction.
  - Non-thermometer valid_i is illegal. RTL still takes lanes 0..K-1. A simulation-only assertion fires.
- Output side:
  - valid_o = all ones when fill >= Width.
  - Otherwise, if flush_pending and fill > 0: valid_o = (1<<fill)-1.
  - Otherwise valid_o = 0.
  - data_o = buffer[Width-1:0], with zero in lanes not covered by valid_o.
  - Outputs are combinational from registers, so latency is 1 cycle from the completing input handshake to valid_o.
  - valid_o/data_o stay stable while valid_o != 0 and ready_i=0.
- Output handshake (valid_o != 0 and ready_i):
  - Removes min(fill, Width) elements and shifts the remainder down to lane 0.
- Simultaneous in/out in one cycle:
  - fill_next = fill - out_count + K.
  - The maximum is Width + Width = 2*Width, which is legal (full). No overflow is possible by construction of ready_o.
- Flush:
  - flush_i sets flush_pending.
  - If fill==0 at the time flush_i is sampled, nothing is set (no-op).
  - flush_pending clears on the output handshake that makes fill 0.
  - With fill > Width, the full word goes out first, then the partial word, then pending clears.
  - flush_i while already pending: no effect.
- States (encoded by fill and flush_pending):
  - FILLING: fill < Width, not pending.
  - FULL: fill >= Width.
  - DRAINING: pending.
  - DRAINING returns to FILLING when fill reaches 0.

Optional Feature:
- Macro: SLINK_REPACK_FLUSH_TIMEOUT_EN.
- When defined:
  - An idle counter of $clog2(FlushTimeout+1) bits increments each cycle with 0 < fill < Width, no input handshake and not pending.
  - The counter resets to 0 on any input handshake, clear_i, flush, or fill==0.
  - Reaching FlushTimeout sets flush_pending exactly as flush_i does.
- When undefined:
  - No counter exists.
  - Partial data waits indefinitely for flush_i.

Test Plan (Width=4, element_t 16-bit):
- Alternate valid_i=4'b0111 inputs A0..A2, B0..B2, C0..C2, D0..D2, with ready_i=1:
  - First output is A0 A1 A2 B0 (valid_o=4'b1111).
  - Second output is B1 B2 C0 C1.
  - Third output is C2 D0 D1 D2.
- Input 4'b0011 {X0,X1}, then flush_i:
  - Next cycle valid_o=4'b0011 with X0 X1.
  - After handshake, fill=0 and ready_o=1.
- Fill to 8 with ready_i=0:
  - ready_o=0.
  - Raise ready_i: two full words in consecutive cycles.
  - Simultaneous input is accepted once fill <= 4.
- Assert rst_i asynchronously with fill=5 mid-burst:
  - valid_o=0 immediately.
  - After release, the first input 4'b1111 emits exactly that word.
- clear_i concurrent with input handshake and flush_i:
  - fill=0, pending=0.
  - The input is dropped.
  - valid_o=0 next cycle.
- With macro, FlushTimeout=8: one input 4'b0001 {Z0}, then idle:
  - valid_o=4'b0001 on the 9th cycle after acceptance.
  - Without macro: valid_o stays 0.

Source files
------------

// File: rtl/slink_channel_repack_buffer.sv
// slink_channel_repack_buffer
// Repacks compacted RX words (only lanes 0..K-1 carry data) into dense
// Width-lane output words. Elements are kept in FIFO order in a 2*Width
// element buffer; lane 0 of the output always holds the oldest element.
// A flush request (or, optionally, an idle timeout) drains a trailing
// partial word.
//
// Optional feature macro: SLINK_REPACK_FLUSH_TIMEOUT_EN
//   When defined, partial data that sits idle for FlushTimeout cycles is
//   flushed automatically. When undefined, partial data waits for flush_i.

module slink_channel_repack_buffer #(
    parameter type         element_t    = logic [15:0],
    parameter int unsigned Width        = 8,
    parameter int unsigned FlushTimeout = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  flush_i,
    input  logic [Width-1:0]      valid_i,
    output logic                  ready_o,
    input  element_t [Width-1:0]  data_i,
    output logic [Width-1:0]      valid_o,
    input  logic                  ready_i,
    output element_t [Width-1:0]  data_o
);

    localparam int unsigned EW    = $bits(element_t);
    localparam int unsigned Depth = 2 * Width;
    localparam int unsigned CW    = $clog2(Depth + 1);
    localparam logic [CW-1:0] WidthC = CW'(Width);

    // Number of set lanes in a lane mask.
    function automatic logic [CW-1:0] popcount(input logic [Width-1:0] v);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int unsigned l = 0; l < Width; l++) begin
            if (v[l]) begin
                cnt = cnt + CW'(1);
            end else begin
                cnt = cnt;
            end
        end
        return cnt;
    endfunction

    // Thermometer mask with the lowest n lanes set.
    function automatic logic [Width-1:0] thermo(input logic [CW-1:0] n);
        logic [Width-1:0] m;
        m = '0;
        for (int unsigned l = 0; l < Width; l++) begin
            m[l] = (l < 32'(n));
        end
        return m;
    endfunction

    logic [CW-1:0]          fill_r;
    logic [CW-1:0]          fill_nxt_s;
    logic [CW-1:0]          fill_eff_s;
    logic [CW-1:0]          out_cnt_s;
    logic [CW-1:0]          k_s;
    logic                   pend_r;
    logic                   pend_nxt_s;
    logic                   full_s;
    logic                   in_hs_s;
    logic                   out_hs_s;
    logic                   flush_req_s;
    logic                   timeout_s;
    logic [Width-1:0]       valid_s;
    logic [Depth*EW-1:0]    buf_r;
    logic [Depth*EW-1:0]    buf_nxt_s;
    logic [Depth*EW-1:0]    shifted_s;
    logic [Depth*EW-1:0]    keep_s;
    logic [Depth*EW-1:0]    ins_s;
    logic [Width*EW-1:0]    din_s;

    // Occupancy status, handshakes and next fill level.
    always_comb begin
        full_s  = (fill_r >= WidthC);
        ready_o = !pend_r && (fill_r <= WidthC);
        if (full_s) begin
            valid_s = '1;
        end else if (pend_r && (fill_r != '0)) begin
            valid_s = thermo(fill_r);
        end else begin
            valid_s = '0;
        end
        k_s      = popcount(valid_i);
        in_hs_s  = (valid_i != '0) && ready_o;
        out_hs_s = (valid_s != '0) && ready_i;
        if (!out_hs_s) begin
            out_cnt_s = '0;
        end else if (full_s) begin
            out_cnt_s = WidthC;
        end else begin
            out_cnt_s = fill_r;
        end
        // Position where new elements land once this cycle's output left.
        fill_eff_s = fill_r - out_cnt_s;
        if (in_hs_s) begin
            fill_nxt_s = fill_eff_s + k_s;
        end else begin
            fill_nxt_s = fill_eff_s;
        end
    end

    // Output word: lowest buffer lanes, zeroed outside the valid mask.
    always_comb begin
        valid_o = valid_s;
        for (int unsigned l = 0; l < Width; l++) begin
            if (valid_s[l]) begin
                data_o[l] = element_t'(buf_r[l*EW +: EW]);
            end else begin
                data_o[l] = element_t'('0);
            end
        end
    end

    // Next buffer contents: drop emitted elements, then append new lanes.
    always_comb begin
        for (int unsigned l = 0; l < Width; l++) begin
            if (l < 32'(k_s)) begin
                din_s[l*EW +: EW] = data_i[l];
            end else begin
                din_s[l*EW +: EW] = '0;
            end
        end
        for (int unsigned p = 0; p < Depth; p++) begin
            if (p < 32'(fill_eff_s)) begin
                keep_s[p*EW +: EW] = '1;
            end else begin
                keep_s[p*EW +: EW] = '0;
            end
        end
        shifted_s = buf_r >> (32'(out_cnt_s) * EW);
        if (in_hs_s) begin
            ins_s = {{(Width*EW){1'b0}}, din_s} << (32'(fill_eff_s) * EW);
        end else begin
            ins_s = '0;
        end
        buf_nxt_s = (shifted_s & keep_s) | ins_s;
    end

`ifdef SLINK_REPACK_FLUSH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(FlushTimeout + 1);

    logic [TW-1:0] idle_r;
    logic [TW-1:0] idle_nxt_s;

    // Idle counter: counts quiet cycles while a partial word waits.
    always_comb begin
        idle_nxt_s = '0;
        timeout_s  = 1'b0;
        if ((fill_r != '0) && !full_s && !in_hs_s && !pend_r && !flush_i) begin
            if (idle_r == TW'(FlushTimeout - 32'd1)) begin
                timeout_s  = 1'b1;
                idle_nxt_s = '0;
            end else begin
                idle_nxt_s = idle_r + TW'(1);
            end
        end else begin
            idle_nxt_s = '0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idle_r <= '0;
        end else if (clear_i) begin
            idle_r <= '0;
        end else begin
            idle_r <= idle_nxt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Flush bookkeeping: a drain ending at fill 0 wins over a new request.
    always_comb begin
        flush_req_s = (flush_i || timeout_s) && (fill_r != '0);
        if (fill_nxt_s == '0) begin
            pend_nxt_s = 1'b0;
        end else if (flush_req_s) begin
            pend_nxt_s = 1'b1;
        end else begin
            pend_nxt_s = pend_r;
        end
    end

    // Buffer, fill level and flush flag; clear_i overrides everything.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_r <= '0;
            pend_r <= 1'b0;
            buf_r  <= '0;
        end else if (clear_i) begin
            fill_r <= '0;
            pend_r <= 1'b0;
            buf_r  <= '0;
        end else begin
            fill_r <= fill_nxt_s;
            pend_r <= pend_nxt_s;
            buf_r  <= buf_nxt_s;
        end
    end

    slink_channel_repack_buffer_checker #(
        .Width        (Width),
        .FlushTimeout (FlushTimeout)
    ) u_checker (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o)
    );

endmodule

// Simulation checks for slink_channel_repack_buffer.
module slink_channel_repack_buffer_checker #(
    parameter int unsigned Width        = 8,
    parameter int unsigned FlushTimeout = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] valid_i,
    input  logic             ready_o
);

    param_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        (Width >= 32'd2) && (FlushTimeout >= 32'd1));

    thermo_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (ready_o && (valid_i != '0)) |-> ((valid_i & (valid_i + Width'(1))) == '0));

endmodule

// File: tb/tb_slink_channel_repack_buffer.sv
module tb_slink_channel_repack_buffer;

    localparam int W  = 4;
    localparam int FT = 8;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                clear_i;
    logic                flush_i;
    logic [W-1:0]        valid_i;
    logic                ready_o;
    logic [W-1:0][15:0]  data_i;
    logic [W-1:0]        valid_o;
    logic                ready_i;
    logic [W-1:0][15:0]  data_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    slink_channel_repack_buffer #(
        .element_t    (logic [15:0]),
        .Width        (W),
        .FlushTimeout (FT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; flush_i = 1'b0;
        valid_i = 4'b0000; data_i = '0; ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", valid_o); end
        checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    endtask

    task automatic test_alternate();
        logic [15:0]        vals [12];
        logic [W-1:0][15:0] words [$];
        logic [W-1:0][15:0] exp_w;
        int g = 0;
        for (int i = 0; i < 12; i++) vals[i] = 16'hA000 + 16'(i);
        ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (g < 4) begin
                valid_i = 4'b0111;
                data_i  = {16'hDEAD, vals[g*3+2], vals[g*3+1], vals[g*3]};
            end else begin
                valid_i = 4'b0000;
                data_i  = '0;
            end
            if (valid_o != 4'b0000) begin
                checks++; if (valid_o !== 4'b1111) begin errors++; $display("FAIL alt_valid: got %b expected 1111", valid_o); end
                words.push_back(data_o);
            end
            if (g < 4 && ready_o) g++;
            tick();
        end
        valid_i = 4'b0000;
        checks++; if (words.size() != 3) begin errors++; $display("FAIL alt_count: got %0d expected 3", words.size()); end
        for (int j = 0; j < 3 && j < words.size(); j++) begin
            exp_w = {vals[4*j+3], vals[4*j+2], vals[4*j+1], vals[4*j]};
            checks++; if (words[j] !== exp_w) begin errors++; $display("FAIL alt_word%0d: got %h expected %h", j, words[j], exp_w); end
        end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL alt_ready_end: got %b expected 1", ready_o); end
    endtask

    task automatic test_flush();
        ready_i = 1'b0;
        valid_i = 4'b0011; data_i = {16'hBAD3, 16'hBAD2, 16'h0F01, 16'h0F00};
        tick();
        valid_i = 4'b0000;
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL flush_partial_idle: got %b expected 0000", valid_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (valid_o !== 4'b0011) begin errors++; $display("FAIL flush_valid: got %b expected 0011", valid_o); end
        checks++; if (data_o !== {16'h0, 16'h0, 16'h0F01, 16'h0F00}) begin errors++; $display("FAIL flush_data: got %h expected 0000000f010f00", data_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready_pending: got %b expected 0", ready_o); end
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL flush_done_valid: got %b expected 0000", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL flush_done_ready: got %b expected 1", ready_o); end
        // Flush while empty is a no-op: a later single element stays buffered.
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 4'b0001; data_i = {16'h0, 16'h0, 16'h0, 16'h1234};
        tick();
        valid_i = 4'b0000;
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL flush_empty_noop: got %b expected 0000", valid_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (data_o !== {16'h0, 16'h0, 16'h0, 16'h1234}) begin errors++; $display("FAIL flush_single_data: got %h expected 1234", data_o); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [W-1:0][15:0] w1, w2, w3;
        w1 = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
        w2 = {16'h2003, 16'h2002, 16'h2001, 16'h2000};
        w3 = {16'h3003, 16'h3002, 16'h3001, 16'h3000};
        ready_i = 1'b0;
        valid_i = 4'b1111; data_i = w1;
        tick();
        data_i = w2;
        tick();
        valid_i = 4'b1111; data_i = w3;
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", ready_o); end
        checks++; if (valid_o !== 4'b1111 || data_o !== w1) begin errors++; $display("FAIL bp_word1: got %b/%h expected 1111/%h", valid_o, data_o, w1); end
        ready_i = 1'b1;
        tick();
        checks++; if (valid_o !== 4'b1111 || data_o !== w2) begin errors++; $display("FAIL bp_word2: got %b/%h expected 1111/%h", valid_o, data_o, w2); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_at4: got %b expected 1", ready_o); end
        tick();
        valid_i = 4'b0000;
        checks++; if (valid_o !== 4'b1111 || data_o !== w3) begin errors++; $display("FAIL bp_word3: got %b/%h expected 1111/%h", valid_o, data_o, w3); end
        tick();
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL bp_drained: got %b expected 0000", valid_o); end
    endtask

    task automatic test_async_reset();
        logic [W-1:0][15:0] wr;
        wr = {16'h7003, 16'h7002, 16'h7001, 16'h7000};
        ready_i = 1'b0;
        valid_i = 4'b1111; data_i = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
        tick();
        valid_i = 4'b0001; data_i = {16'h0, 16'h0, 16'h0, 16'h5004};
        tick();
        valid_i = 4'b0000;
        checks++; if (valid_o !== 4'b1111) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1111", valid_o); end
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL arst_valid_now: got %b expected 0000", valid_o); end
        checks++; if (data_o !== 64'h0) begin errors++; $display("FAIL arst_data_now: got %h expected 0", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        valid_i = 4'b1111; data_i = wr; ready_i = 1'b1;
        tick();
        valid_i = 4'b0000;
        checks++; if (valid_o !== 4'b1111 || data_o !== wr) begin errors++; $display("FAIL arst_first_word: got %b/%h expected 1111/%h", valid_o, data_o, wr); end
        tick();
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL arst_after_word: got %b expected 0000", valid_o); end
    endtask

    task automatic test_clear();
        ready_i = 1'b0;
        valid_i = 4'b0011; data_i = {16'h0, 16'h0, 16'hC001, 16'hC000};
        tick();
        valid_i = 4'b0111; data_i = {16'h0, 16'hC004, 16'hC003, 16'hC002};
        flush_i = 1'b1; clear_i = 1'b1;
        tick();
        valid_i = 4'b0000; flush_i = 1'b0; clear_i = 1'b0;
        checks++; if (valid_o !== 4'b0000) begin errors++; $display("FAIL clear_valid: got %b expected 0000", valid_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL clear_ready: got %b expected 1", ready_o); end
        valid_i = 4'b0001; data_i = {16'h0, 16'h0, 16'h0, 16'hC0DE};
        tick();
        valid_i = 4'b0000; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (valid_o !== 4'b0001 || data_o !== {16'h0, 16'h0, 16'h0, 16'hC0DE}) begin errors++; $display("FAIL clear_dropped: got %b/%h expected 0001/c0de", valid_o, data_o); end
        ready_i = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        int                 first = 0;
        logic [W-1:0]       seen_v = '0;
        logic [W-1:0][15:0] seen_d = '0;
        ready_i = 1'b1;
        valid_i = 4'b0001; data_i = {16'h0, 16'h0, 16'h0, 16'h2E00};
        tick();
        valid_i = 4'b0000;
        for (int c = 1; c <= 20; c++) begin
            if (valid_o != 4'b0000 && first == 0) begin
                first = c; seen_v = valid_o; seen_d = data_o;
            end
            tick();
        end
`ifdef SLINK_REPACK_FLUSH_TIMEOUT_EN
        checks++; if (first != 9) begin errors++; $display("FAIL timeout_cycle: got %0d expected 9", first); end
        checks++; if (seen_v !== 4'b0001 || seen_d !== {16'h0, 16'h0, 16'h0, 16'h2E00}) begin errors++; $display("FAIL timeout_word: got %b/%h expected 0001/2e00", seen_v, seen_d); end
`else
        checks++; if (first != 0) begin errors++; $display("FAIL no_timeout: got valid at cycle %0d expected none", first); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++; if (valid_o !== 4'b0001 || data_o !== {16'h0, 16'h0, 16'h0, 16'h2E00}) begin errors++; $display("FAIL hold_word: got %b/%h expected 0001/2e00", valid_o, data_o); end
        tick();
`endif
    endtask

    task automatic test_random();
        logic [15:0]        q [$];
        bit                 mpend = 1'b0;
        int                 nvalid, sz0, k;
        bit                 exp_ready, in_hs, out_hs, fl;
        logic [W-1:0]       exp_valid;
        logic [W-1:0][15:0] exp_data;
`ifdef SLINK_REPACK_FLUSH_TIMEOUT_EN
        int                 midle = 0;
`endif
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        for (int c = 0; c < 800; c++) begin
            k = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, W));
            valid_i = 4'((1 << k) - 1);
            for (int l = 0; l < W; l++) data_i[l] = 16'($urandom);
            flush_i = ($urandom_range(0, 15) == 0);
            ready_i = ($urandom_range(0, 3) != 0);
            clear_i = ($urandom_range(0, 99) == 0);
            if ((c / 100) % 2 == 1 && $urandom_range(0, 3) != 0) begin
                valid_i = 4'b0000; k = 0; flush_i = 1'b0;
            end
            // Expected outputs from the element queue and pending flag.
            if (q.size() >= W) nvalid = W;
            else if (mpend) nvalid = q.size();
            else nvalid = 0;
            exp_valid = 4'((1 << nvalid) - 1);
            exp_ready = !mpend && (q.size() <= W);
            for (int l = 0; l < W; l++) exp_data[l] = (l < nvalid) ? q[l] : 16'h0;
            checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, ready_o, exp_ready); end
            checks++; if (valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, valid_o, exp_valid); end
            checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rnd_data c%0d: got %h expected %h", c, data_o, exp_data); end
            // Advance the model across the coming edge.
            if (clear_i) begin
                q.delete(); mpend = 1'b0;
`ifdef SLINK_REPACK_FLUSH_TIMEOUT_EN
                midle = 0;
`endif
            end else begin
                sz0 = q.size();
                in_hs = (k != 0) && exp_ready;
                out_hs = (nvalid != 0) && ready_i;
                if (out_hs) repeat (nvalid) void'(q.pop_front());
                if (in_hs) for (int l = 0; l < k; l++) q.push_back(data_i[l]);
                fl = flush_i;
`ifdef SLINK_REPACK_FLUSH_TIMEOUT_EN
                if (sz0 > 0 && sz0 < W && !in_hs && !mpend && !flush_i) begin
                    midle++;
                    if (midle == FT) begin fl = 1'b1; midle = 0; end
                end else begin
                    midle = 0;
                end
`endif
                if (fl && sz0 != 0) mpend = 1'b1;
                if (q.size() == 0) mpend = 1'b0;
            end
            tick();
        end
        valid_i = 4'b0000; flush_i = 1'b0; clear_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_flush();
        test_backpressure();
        test_async_reset();
        test_clear();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
